sig_trace_writer: RTL and testbench

- Writer side of the shared signal-trace memory that the VGA display scans.
- Accepts 12-bit ECG (ch0) and EMG (ch1) samples over a valid/ready handshake and decimates each channel independently.
- Writes the kept samples, in sweep (oscilloscope) order, into one circular window per channel through the memory's single write port.
- The display reads ch0 at CH0_BASE+x and ch1 at CH1_BASE+x, and uses data bits [11:4].

---
 rtl/sig_trace_writer.sv | 231 +++++++++++++++++++++++
 tb/tb_sig_trace_writer.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_trace_writer.sv
// -----------------------------------------------------------------------------
// sig_trace_writer
//
// Writer side of the shared signal-trace memory scanned by the VGA display.
// Two sample streams (ch0 = ECG, ch1 = EMG) arrive over valid/ready
// handshakes. Each channel is decimated on its own, and the kept samples are
// written in sweep order into a circular window per channel. All writes share
// one memory write port.
//
// Handshake: a sample transfers on a rising clock edge where valid && ready.
// ready never depends on valid. Data must be stable while valid is high.
// ready is low while reset is asserted and rises one cycle after release.
//
// Ports:
//   clock       system clock (also the memory write-port clock)
//   reset       asynchronous, active-low; clears all state while low
//   ch0_data    ECG sample, 12-bit unsigned
//   ch0_valid   ECG sample offered
//   ch0_ready   ECG sample accepted when valid && ready
//   ch1_data    EMG sample, 12-bit unsigned
//   ch1_valid   EMG sample offered
//   ch1_ready   EMG sample accepted when valid && ready
//   decim0      ch0 keeps one sample in (decim0 + 1)
//   decim1      ch1 keeps one sample in (decim1 + 1)
//   freeze      hold the picture: samples are accepted and discarded, no writes
//   mem_addr    write address (holds its value when idle)
//   mem_wdata   write data, {20'b0, saturated sample} (holds when idle)
//   mem_we      write strobe, at most one word per cycle
//   sweep_done  per-channel one-cycle pulse on the write that wraps the index
// -----------------------------------------------------------------------------
module sig_trace_writer #(
  parameter logic [11:0] CH0_BASE = 12'h801,
  parameter logic [11:0] CH1_BASE = 12'h6AC,
  parameter int          DEPTH    = 640,
  parameter int          DECIM_W  = 8,
  parameter logic [11:0] SAT_MAX  = 12'hEFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        ch0_data,
  input  logic               ch0_valid,
  output logic               ch0_ready,
  input  logic [11:0]        ch1_data,
  input  logic               ch1_valid,
  output logic               ch1_ready,
  input  logic [DECIM_W-1:0] decim0,
  input  logic [DECIM_W-1:0] decim1,
  input  logic               freeze,
  output logic [11:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_we,
  output logic [1:0]         sweep_done
);

  localparam int             IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // en_q keeps ready low during reset and for the first cycle after release.
  logic               en_q,    en_d;

  logic               full0_q, full0_d;
  logic [11:0]        hold0_q, hold0_d;
  logic [DECIM_W-1:0] dcnt0_q, dcnt0_d;
  logic [IDX_W-1:0]   idx0_q,  idx0_d;

  logic               full1_q, full1_d;
  logic [11:0]        hold1_q, hold1_d;
  logic [DECIM_W-1:0] dcnt1_q, dcnt1_d;
  logic [IDX_W-1:0]   idx1_q,  idx1_d;

  // Round-robin pointer: 0 means ch0 wins the next contended cycle.
  logic               rr_q,    rr_d;

  logic               mem_we_q,    mem_we_d;
  logic [11:0]        mem_addr_q,  mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [1:0]         sweep_q,     sweep_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic        can_wr0, can_wr1;
  logic        grant0,  grant1;
  logic        acc0,    acc1;
  logic        keep0,   keep1;
  logic        wrap0,   wrap1;
  logic [11:0] sat0,    sat1;

  always_comb begin
    // A full register may only write while the display is not frozen; a
    // frozen register keeps its sample until freeze drops.
    can_wr0 = full0_q && !freeze;
    can_wr1 = full1_q && !freeze;

    grant0  = can_wr0 && (!can_wr1 || !rr_q);
    grant1  = can_wr1 && (!can_wr0 ||  rr_q);

    // The register that is being drained this edge can take a new sample on
    // the same edge, which gives one sample per cycle when uncontended.
    ch0_ready = en_q && (!full0_q || grant0);
    ch1_ready = en_q && (!full1_q || grant1);

    acc0  = ch0_valid && ch0_ready;
    acc1  = ch1_valid && ch1_ready;

    keep0 = acc0 && (dcnt0_q == '0);
    keep1 = acc1 && (dcnt1_q == '0);

    wrap0 = (idx0_q == IDX_LAST);
    wrap1 = (idx1_q == IDX_LAST);

    sat0  = (hold0_q > SAT_MAX) ? SAT_MAX : hold0_q;
    sat1  = (hold1_q > SAT_MAX) ? SAT_MAX : hold1_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    en_d        = 1'b1;

    full0_d     = full0_q;
    hold0_d     = hold0_q;
    dcnt0_d     = dcnt0_q;
    idx0_d      = idx0_q;

    full1_d     = full1_q;
    hold1_d     = hold1_q;
    dcnt1_d     = dcnt1_q;
    idx1_d      = idx1_q;

    rr_d        = rr_q;

    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sweep_d     = 2'b00;

    // Decimation counters advance on every accepted sample, frozen or not.
    // The ratio is re-read at each reload so a change applies from the next
    // kept sample onward.
    if (acc0) begin
      dcnt0_d = (dcnt0_q == '0) ? decim0 : dcnt0_q - 1'b1;
    end
    if (acc1) begin
      dcnt1_d = (dcnt1_q == '0) ? decim1 : dcnt1_q - 1'b1;
    end

    // Drain first, then load, so a same-edge drain and refill leaves the
    // register full with the new sample.
    if (grant0) begin
      full0_d = 1'b0;
      idx0_d  = wrap0 ? '0 : idx0_q + 1'b1;
    end
    if (grant1) begin
      full1_d = 1'b0;
      idx1_d  = wrap1 ? '0 : idx1_q + 1'b1;
    end

    if (keep0 && !freeze) begin
      full0_d = 1'b1;
      hold0_d = ch0_data;
    end
    if (keep1 && !freeze) begin
      full1_d = 1'b1;
      hold1_d = ch1_data;
    end

    // Single write port. Base plus index is a plain 12-bit add; any carry
    // out of bit 11 is discarded.
    if (grant0) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = CH0_BASE + 12'(idx0_q);
      mem_wdata_d = {20'b0, sat0};
      sweep_d[0]  = wrap0;
      rr_d        = 1'b1;
    end else if (grant1) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = CH1_BASE + 12'(idx1_q);
      mem_wdata_d = {20'b0, sat1};
      sweep_d[1]  = wrap1;
      rr_d        = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q        <= 1'b0;
      full0_q     <= 1'b0;
      hold0_q     <= '0;
      dcnt0_q     <= '0;
      idx0_q      <= '0;
      full1_q     <= 1'b0;
      hold1_q     <= '0;
      dcnt1_q     <= '0;
      idx1_q      <= '0;
      rr_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sweep_q     <= 2'b00;
    end else begin
      en_q        <= en_d;
      full0_q     <= full0_d;
      hold0_q     <= hold0_d;
      dcnt0_q     <= dcnt0_d;
      idx0_q      <= idx0_d;
      full1_q     <= full1_d;
      hold1_q     <= hold1_d;
      dcnt1_q     <= dcnt1_d;
      idx1_q      <= idx1_d;
      rr_q        <= rr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sweep_q     <= sweep_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign sweep_done = sweep_q;

endmodule

// File: tb/tb_sig_trace_writer.sv
// -----------------------------------------------------------------------------
// tb_sig_trace_writer
//
// Bench for sig_trace_writer. A reference model turns every accepted sample
// into an expected (wrap, address, data) entry per channel using the keep-one-
// in-N rule, the window base, a wrapping index and the saturation ceiling. A
// monitor matches each observed write against the head of either channel's
// queue. Scenario tasks add directed timing and content checks.
// -----------------------------------------------------------------------------
module tb_sig_trace_writer;

  localparam logic [11:0] CH0_BASE = 12'h801;
  localparam logic [11:0] CH1_BASE = 12'h6AC;
  localparam int          DEPTH    = 640;
  localparam logic [11:0] SAT_MAX  = 12'hEFF;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] ch0_data = '0;
  logic        ch0_valid = 1'b0;
  logic        ch0_ready;
  logic [11:0] ch1_data = '0;
  logic        ch1_valid = 1'b0;
  logic        ch1_ready;
  logic [7:0]  decim0 = '0;
  logic [7:0]  decim1 = '0;
  logic        freeze = 1'b0;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  sweep_done;

  always #5 clock = ~clock;

  sig_trace_writer dut (
    .clock      (clock),
    .reset      (reset),
    .ch0_data   (ch0_data),
    .ch0_valid  (ch0_valid),
    .ch0_ready  (ch0_ready),
    .ch1_data   (ch1_data),
    .ch1_valid  (ch1_valid),
    .ch1_ready  (ch1_ready),
    .decim0     (decim0),
    .decim1     (decim1),
    .freeze     (freeze),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .sweep_done (sweep_done)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [44:0] exp0_q[$];   // {wrap, addr[11:0], wdata[31:0]}
  logic [44:0] exp1_q[$];
  logic [43:0] obs_q[$];    // {addr, wdata} of every observed write
  int          sw0_cnt = 0;
  int          m_idx[2];
  int          m_dc[2];

  function automatic void model_clear();
    exp0_q.delete();
    exp1_q.delete();
    obs_q.delete();
    sw0_cnt = 0;
    m_idx[0] = 0; m_idx[1] = 0;
    m_dc[0]  = 0; m_dc[1]  = 0;
  endfunction

  function automatic void model_accept(input int c, input logic [11:0] d);
    logic [11:0] base;
    logic [11:0] sat;
    logic [44:0] e;
    if (m_dc[c] == 0) begin
      if (!freeze) begin
        base = (c == 0) ? CH0_BASE : CH1_BASE;
        sat  = (d > SAT_MAX) ? SAT_MAX : d;
        e    = {(m_idx[c] == DEPTH - 1), 12'(int'(base) + m_idx[c]), 20'd0, sat};
        if (c == 0) exp0_q.push_back(e);
        else        exp1_q.push_back(e);
        m_idx[c] = (m_idx[c] + 1) % DEPTH;
      end
      m_dc[c] = (c == 0) ? int'(decim0) : int'(decim1);
    end else begin
      m_dc[c] = m_dc[c] - 1;
    end
  endfunction

  // Monitor: every write must be the next expected entry of one channel,
  // carrying the right sweep_done bit; idle cycles carry no sweep pulse.
  logic [44:0] mon_f;
  logic        mon_hit;
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (mem_we === 1'b1) begin
        obs_q.push_back({mem_addr, mem_wdata});
        if (sweep_done[0] === 1'b1) sw0_cnt++;
        checks++;
        mon_hit = 1'b0;
        if (exp0_q.size() > 0) begin
          mon_f = exp0_q[0];
          if (mon_f[43:0] == {mem_addr, mem_wdata}) begin
            mon_hit = 1'b1;
            mon_f   = exp0_q.pop_front();
            if (sweep_done !== {1'b0, mon_f[44]}) begin
              errors++;
              $display("FAIL wr_sweep0: sweep_done=%b required %b at addr %h",
                       sweep_done, {1'b0, mon_f[44]}, mem_addr);
            end
          end
        end
        if (!mon_hit && exp1_q.size() > 0) begin
          mon_f = exp1_q[0];
          if (mon_f[43:0] == {mem_addr, mem_wdata}) begin
            mon_hit = 1'b1;
            mon_f   = exp1_q.pop_front();
            if (sweep_done !== {mon_f[44], 1'b0}) begin
              errors++;
              $display("FAIL wr_sweep1: sweep_done=%b required %b at addr %h",
                       sweep_done, {mon_f[44], 1'b0}, mem_addr);
            end
          end
        end
        if (!mon_hit) begin
          errors++;
          $display("FAIL wr_content: got addr %h data %h, required ch0 head %h or ch1 head %h",
                   mem_addr, mem_wdata,
                   (exp0_q.size() > 0) ? exp0_q[0][43:0] : 44'h0,
                   (exp1_q.size() > 0) ? exp1_q[0][43:0] : 44'h0);
        end
      end else begin
        checks++;
        if (sweep_done !== 2'b00) begin
          errors++;
          $display("FAIL idle_sweep: sweep_done=%b required 00 with mem_we=%b",
                   sweep_done, mem_we);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One cycle of stimulus. Returns at posedge+1 with the acceptance flags.
  task automatic cyc(input logic v0, input logic [11:0] d0,
                     input logic v1, input logic [11:0] d1,
                     output logic a0, output logic a1);
    @(negedge clock);
    ch0_valid = v0; ch0_data = d0;
    ch1_valid = v1; ch1_data = d1;
    #1;
    a0 = v0 && ch0_ready;
    a1 = v1 && ch1_ready;
    if (a0) model_accept(0, d0);
    if (a1) model_accept(1, d1);
    @(posedge clock);
    #1;
  endtask

  // Offer one sample on channel c until taken; a timeout counts as a failure.
  task automatic send(input int c, input logic [11:0] d);
    logic a0, a1;
    bit   done;
    done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (c == 0) cyc(1'b1, d, 1'b0, 12'h0, a0, a1);
      else        cyc(1'b0, 12'h0, 1'b1, d, a0, a1);
      done = (c == 0) ? a0 : a1;
    end
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ch%0d sample %h not accepted, required acceptance within 8 cycles", c, d);
    end
  endtask

  task automatic drain(input string name);
    @(negedge clock);
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    freeze    = 1'b0;
    for (int i = 0; i < 20 && (exp0_q.size() + exp1_q.size()) > 0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending ch0=%0d ch1=%0d, required 0 0",
               name, exp0_q.size(), exp1_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    freeze = 1'b0; decim0 = '0; decim1 = '0;
    #1;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 12'h0 || mem_wdata !== 32'h0 || sweep_done !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%h wdata=%h sweep=%b, required 0 0 0 0",
               mem_we, mem_addr, mem_wdata, sweep_done);
    end
    checks++;
    if (ch0_ready !== 1'b0 || ch1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b%b, required 00", ch1_ready, ch0_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ch0_ready !== 1'b0 || ch1_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_ready_early: ready=%b%b, required 00", ch1_ready, ch0_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (ch0_ready !== 1'b1 || ch1_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: ready=%b%b, required 11", ch1_ready, ch0_ready);
    end
    model_clear();
  endtask

  task automatic test_seq();
    logic [11:0] d [3];
    logic a0, a1;
    d[0] = 12'h100; d[1] = 12'h200; d[2] = 12'h300;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, d[i], 1'b0, 12'h0, a0, a1);
      checks++;
      if (a0 !== 1'b1) begin
        errors++;
        $display("FAIL seq_accept: sample %0d accepted=%b, required 1", i, a0);
      end
      @(negedge clock);
      ch0_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL seq_early: mem_we=%b right after accept, required 0", mem_we);
      end
      @(posedge clock);
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 12'(CH0_BASE + i) || mem_wdata !== {20'd0, d[i]}) begin
        errors++;
        $display("FAIL seq_write: we=%b addr=%h data=%h, required 1 %h %h",
                 mem_we, mem_addr, mem_wdata, 12'(CH0_BASE + i), {20'd0, d[i]});
      end
    end
    drain("seq");
  endtask

  task automatic test_alternate();
    logic a0, a1;
    int n0, n1;
    logic [11:0] ea;
    logic [43:0] o;
    do_reset();
    n0 = 0; n1 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 12'h111, 1'b1, 12'h222, a0, a1);
      n0 += int'(a0);
      n1 += int'(a1);
    end
    drain("alt");
    checks++;
    if (n0 < 10 || n0 > 11 || n1 < 10 || n1 > 11) begin
      errors++;
      $display("FAIL alt_rate: accepts ch0=%0d ch1=%0d in 20 cycles, required 10..11 each", n0, n1);
    end
    checks++;
    if (obs_q.size() < 8) begin
      errors++;
      $display("FAIL alt_count: %0d writes, required at least 8", obs_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        o  = obs_q[k];
        ea = (k % 2 == 0) ? 12'(CH0_BASE + k / 2) : 12'(CH1_BASE + k / 2);
        checks++;
        if (o[43:32] !== ea) begin
          errors++;
          $display("FAIL alt_order: write %0d addr %h, required %h", k, o[43:32], ea);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic a0, a1;
    int   acc;
    logic [43:0] o;
    do_reset();
    acc = 0;
    for (int i = 0; i < 2000 && acc < DEPTH + 1; i++) begin
      cyc(1'b1, 12'($urandom_range(0, 4095)), 1'b0, 12'h0, a0, a1);
      acc += int'(a0);
    end
    drain("wrap");
    checks++;
    if (obs_q.size() != DEPTH + 1) begin
      errors++;
      $display("FAIL wrap_count: %0d writes, required %0d", obs_q.size(), DEPTH + 1);
    end else begin
      o = obs_q[DEPTH - 1];
      checks++;
      if (o[43:32] !== 12'hA80) begin
        errors++;
        $display("FAIL wrap_last: addr %h, required a80", o[43:32]);
      end
      o = obs_q[DEPTH];
      checks++;
      if (o[43:32] !== 12'h801) begin
        errors++;
        $display("FAIL wrap_first: addr %h, required 801", o[43:32]);
      end
    end
    checks++;
    if (sw0_cnt != 1) begin
      errors++;
      $display("FAIL wrap_pulses: sweep_done[0] pulses %0d, required 1", sw0_cnt);
    end
  endtask

  task automatic test_decim();
    logic [43:0] o;
    do_reset();
    decim1 = 8'd3;
    for (int i = 0; i < 12; i++) send(1, 12'(i));
    drain("decim");
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL decim_count: %0d writes, required 3", obs_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        o = obs_q[k];
        checks++;
        if (o !== {12'(CH1_BASE + k), 32'(4 * k)}) begin
          errors++;
          $display("FAIL decim_write: write %0d %h, required %h", k, o, {12'(CH1_BASE + k), 32'(4 * k)});
        end
      end
    end
  endtask

  task automatic test_sat();
    logic [11:0] d [4];
    logic [31:0] e [4];
    logic [43:0] o;
    d[0] = 12'hFFF; d[1] = 12'h7A0; d[2] = 12'hEFF; d[3] = 12'hF00;
    e[0] = 32'h00000EFF; e[1] = 32'h000007A0; e[2] = 32'h00000EFF; e[3] = 32'h00000EFF;
    do_reset();
    for (int i = 0; i < 4; i++) send(0, d[i]);
    drain("sat");
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL sat_count: %0d writes, required 4", obs_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        o = obs_q[k];
        checks++;
        if (o[31:0] !== e[k]) begin
          errors++;
          $display("FAIL sat_data: sample %h wrote %h, required %h", d[k], o[31:0], e[k]);
        end
      end
    end
  endtask

  task automatic test_freeze();
    logic [43:0] o;
    do_reset();
    send(0, 12'h010);
    send(0, 12'h020);
    drain("frz_pre");
    // Frozen samples are taken and thrown away; the decimation counter still
    // steps, leaving one sample to drop after freeze is released.
    decim0 = 8'd1;
    freeze = 1'b1;
    for (int i = 0; i < 11; i++) send(0, 12'(12'h500 + i));
    repeat (3) @(negedge clock);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL frz_nowrite: %0d writes during freeze, required 2 total", obs_q.size());
    end
    freeze = 1'b0;
    decim0 = 8'd0;
    send(0, 12'h030);
    send(0, 12'h031);
    drain("frz_post");
    o = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : 44'h0;
    checks++;
    if (obs_q.size() != 3 || o !== {12'h803, 32'h031}) begin
      errors++;
      $display("FAIL frz_resume: %0d writes last %h, required 3 writes last %h",
               obs_q.size(), o, {12'h803, 32'h031});
    end
    // A register that is already full when freeze rises is held and written
    // only after release.
    send(0, 12'h040);
    freeze = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL frz_hold: %0d writes while held, required 3", obs_q.size());
    end
    drain("frz_hold");
    o = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : 44'h0;
    checks++;
    if (o !== {12'h804, 32'h040}) begin
      errors++;
      $display("FAIL frz_release: last write %h, required %h", o, {12'h804, 32'h040});
    end
  endtask

  task automatic test_reset_mid();
    logic a0, a1;
    logic [43:0] o;
    do_reset();
    cyc(1'b1, 12'hAAA, 1'b1, 12'hBBB, a0, a1);
    @(negedge clock);
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_prewrite: mem_we=%b, required 1", mem_we);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || ch0_ready !== 1'b0 || ch1_ready !== 1'b0 || sweep_done !== 2'b00) begin
      errors++;
      $display("FAIL mid_async: we=%b ready=%b%b sweep=%b, required 0 00 00",
               mem_we, ch1_ready, ch0_ready, sweep_done);
    end
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    send(1, 12'h0BB);
    send(0, 12'h0AA);
    drain("mid");
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL mid_count: %0d writes after reset, required 2", obs_q.size());
    end else begin
      o = obs_q[0];
      checks++;
      if (o !== {CH1_BASE, 32'h0BB}) begin
        errors++;
        $display("FAIL mid_first1: %h, required %h", o, {CH1_BASE, 32'h0BB});
      end
      o = obs_q[1];
      checks++;
      if (o !== {CH0_BASE, 32'h0AA}) begin
        errors++;
        $display("FAIL mid_first0: %h, required %h", o, {CH0_BASE, 32'h0AA});
      end
    end
  endtask

  task automatic test_random();
    logic a0, a1;
    do_reset();
    decim0 = 8'($urandom_range(0, 3));
    decim1 = 8'($urandom_range(0, 3));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 31) == 0) decim0 = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) decim1 = 8'($urandom_range(0, 3));
      freeze = ($urandom_range(0, 15) == 0);
      cyc(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
          1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), a0, a1);
    end
    drain("rand");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_seq();
    test_alternate();
    test_wrap();
    test_decim();
    test_sat();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
